// File: rtl/ann_pkg.sv
// Shared constants and types for the output layer and the argmax stage.
package ann_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int CLASS_COUNT = 10;
  localparam int IDX_WIDTH   = $clog2(CLASS_COUNT);

  typedef logic [DATA_WIDTH-1:0] score_t;
  typedef logic [IDX_WIDTH-1:0]  class_idx_t;

  typedef enum logic {ACCUM, DONE} argmax_state_t;

  localparam class_idx_t LAST_IDX = class_idx_t'(CLASS_COUNT - 1);
endpackage

// File: rtl/argmax_update.sv
// Combinational running-max step: folds one score into best/idx (and runner-up with ARGMAX_MARGIN_EN).
// Zero latency; no flow control of its own, the caller decides when to register.
module argmax_update
  import ann_pkg::*;
(
  input  logic       first,
  input  class_idx_t cnt,
  input  score_t     score,
  input  score_t     best,
  input  class_idx_t best_idx,
`ifdef ARGMAX_MARGIN_EN
  input  score_t     second,
  output score_t     nxt_second,
`endif
  output score_t     nxt_best,
  output class_idx_t nxt_idx
);

  always_comb begin
    nxt_best = best;
    nxt_idx  = best_idx;
`ifdef ARGMAX_MARGIN_EN
    nxt_second = second;
`endif
    if (first) begin
      nxt_best = score;
      nxt_idx  = '0;
`ifdef ARGMAX_MARGIN_EN
      nxt_second = '0;
`endif
    end else if (score > best) begin
      // Strict compare keeps the earliest index on ties.
`ifdef ARGMAX_MARGIN_EN
      nxt_second = best;
`endif
      nxt_best = score;
      nxt_idx  = cnt;
    end
`ifdef ARGMAX_MARGIN_EN
    else if (score > second) begin
      nxt_second = score;
    end
`endif
  end

endmodule

// File: rtl/output_argmax.sv
// Picks the winning class from a serial stream of CLASS_COUNT scores; result valid the cycle after the last beat.
// Holds the result until class_ready; score_ready is low while a result is pending. Margin output: ARGMAX_MARGIN_EN.
module output_argmax
  import ann_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       score_valid,
  output logic       score_ready,
  input  score_t     score_data,
  output logic       class_valid,
  input  logic       class_ready,
  output class_idx_t class_idx,
`ifdef ARGMAX_MARGIN_EN
  output score_t     class_margin,
`endif
  output score_t     class_score
);

  argmax_state_t state, state_nxt;
  class_idx_t    cnt;
  score_t        best, nxt_best;
  class_idx_t    best_idx, nxt_idx;
`ifdef ARGMAX_MARGIN_EN
  score_t        second, nxt_second;
`endif

  logic beat;
  logic last;

  assign score_ready = (state == ACCUM);
  assign class_valid = (state == DONE);
  assign beat        = score_valid && score_ready;
  assign last        = (cnt == LAST_IDX);

  argmax_update u_update (
    .first    (cnt == '0),
    .cnt      (cnt),
    .score    (score_data),
    .best     (best),
    .best_idx (best_idx),
`ifdef ARGMAX_MARGIN_EN
    .second     (second),
    .nxt_second (nxt_second),
`endif
    .nxt_best (nxt_best),
    .nxt_idx  (nxt_idx)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (beat && last) state_nxt = DONE;
      DONE:    if (class_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      cnt         <= '0;
      best        <= '0;
      best_idx    <= '0;
      class_idx   <= '0;
      class_score <= '0;
`ifdef ARGMAX_MARGIN_EN
      second       <= '0;
      class_margin <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (beat) begin
        best     <= nxt_best;
        best_idx <= nxt_idx;
`ifdef ARGMAX_MARGIN_EN
        second <= nxt_second;
`endif
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          class_idx   <= nxt_idx;
          class_score <= nxt_best;
`ifdef ARGMAX_MARGIN_EN
          class_margin <= nxt_best - nxt_second;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
// Directed self-checking bench for output_argmax; margin checks follow ARGMAX_MARGIN_EN.
module tb_output_argmax;
  import ann_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       score_valid = 1'b0;
  logic       score_ready;
  score_t     score_data = '0;
  logic       class_valid;
  logic       class_ready = 1'b0;
  class_idx_t class_idx;
  score_t     class_score;
`ifdef ARGMAX_MARGIN_EN
  score_t     class_margin;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  output_argmax dut (
    .clk         (clk),
    .rst         (rst),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .score_data  (score_data),
    .class_valid (class_valid),
    .class_ready (class_ready),
    .class_idx   (class_idx),
`ifdef ARGMAX_MARGIN_EN
    .class_margin(class_margin),
`endif
    .class_score (class_score)
  );

  // Streams one frame; bubble_mod>0 drops valid on every bubble_mod-th cycle.
  // Returns at the negedge after the last accepted beat; cycles = posedges used.
  task automatic send_frame(input score_t v[CLASS_COUNT], input int bubble_mod, output int cycles);
    int  k;
    logic acc;
    k = 0;
    cycles = 0;
    while (k < CLASS_COUNT && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (bubble_mod != 0 && (cycles % bubble_mod) == 0) begin
        score_valid = 1'b0;
        score_data  = 32'hDEAD_BEEF;
      end else begin
        score_valid = 1'b1;
        score_data  = v[k];
      end
      acc = score_valid && score_ready;
      @(posedge clk);
      if (acc) k++;
    end
    @(negedge clk);
    score_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (score_ready !== 1'b1 || class_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_handshake: score_ready=%b class_valid=%b, required 1/0", score_ready, class_valid);
    end
    tests++;
    if (class_idx !== '0 || class_score !== '0) begin
      fails++;
      $display("FAIL reset_outputs: idx=%0d score=%0d, required 0/0", class_idx, class_score);
    end
    rst = 1'b0;
  endtask

  task automatic test_tie;
    score_t f[CLASS_COUNT] = '{32'd5, 32'd9, 32'd3, 32'd12, 32'd0, 32'd7, 32'd12, 32'd1, 32'd4, 32'd2};
    int cyc;
    send_frame(f, 0, cyc);
    tests++;
    if (cyc !== 10 || class_valid !== 1'b1) begin
      fails++;
      $display("FAIL tie_latency: cycles=%0d class_valid=%b, required 10/1", cyc, class_valid);
    end
    tests++;
    if (class_idx !== class_idx_t'(3) || class_score !== 32'd12) begin
      fails++;
      $display("FAIL tie_result: idx=%0d score=%0d, required 3/12", class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    tests++;
    if (class_margin !== 32'd0) begin
      fails++;
      $display("FAIL tie_margin: margin=%0d, required 0", class_margin);
    end
`endif
    tests++;
    if (score_ready !== 1'b0) begin
      fails++;
      $display("FAIL done_score_ready: score_ready=%b, required 0", score_ready);
    end
    class_ready = 1'b1;
    @(negedge clk);
    class_ready = 1'b0;
    tests++;
    if (class_valid !== 1'b0 || score_ready !== 1'b1) begin
      fails++;
      $display("FAIL tie_handshake: class_valid=%b score_ready=%b, required 0/1", class_valid, score_ready);
    end
    tests++;
    if (class_idx !== class_idx_t'(3) || class_score !== 32'd12) begin
      fails++;
      $display("FAIL tie_hold_after: idx=%0d score=%0d, required 3/12", class_idx, class_score);
    end
  endtask

  task automatic test_all_zero;
    score_t f[CLASS_COUNT] = '{default: 32'd0};
    int cyc;
    send_frame(f, 0, cyc);
    tests++;
    if (class_valid !== 1'b1 || class_idx !== '0 || class_score !== '0) begin
      fails++;
      $display("FAIL all_zero: valid=%b idx=%0d score=%0d, required 1/0/0", class_valid, class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    tests++;
    if (class_margin !== 32'd0) begin
      fails++;
      $display("FAIL all_zero_margin: margin=%0d, required 0", class_margin);
    end
`endif
    class_ready = 1'b1;
    @(negedge clk);
    class_ready = 1'b0;
  endtask

  task automatic test_stall;
    score_t f[CLASS_COUNT] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd100};
    int cyc;
    int bad;
    send_frame(f, 0, cyc);
    tests++;
    if (class_idx !== class_idx_t'(9) || class_score !== 32'd100) begin
      fails++;
      $display("FAIL last_wins: idx=%0d score=%0d, required 9/100", class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    tests++;
    if (class_margin !== 32'd100) begin
      fails++;
      $display("FAIL last_wins_margin: margin=%0d, required 100", class_margin);
    end
`endif
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (class_valid !== 1'b1 || score_ready !== 1'b0 ||
          class_idx !== class_idx_t'(9) || class_score !== 32'd100) bad++;
      score_valid = 1'b1;
      score_data  = 32'd77;
      @(negedge clk);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL stall_stable: %0d unstable cycles, required 0", bad);
    end
    score_valid = 1'b0;
    class_ready = 1'b1;
    @(negedge clk);
    class_ready = 1'b0;
    tests++;
    if (class_valid !== 1'b0 || score_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: class_valid=%b score_ready=%b, required 0/1", class_valid, score_ready);
    end
  endtask

  task automatic test_bubbles;
    score_t f[CLASS_COUNT] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
    int cyc;
    send_frame(f, 3, cyc);
    tests++;
    if (cyc !== 14) begin
      fails++;
      $display("FAIL bubble_cycles: cycles=%0d, required 14", cyc);
    end
    tests++;
    if (class_valid !== 1'b1 || class_idx !== class_idx_t'(9) || class_score !== 32'd10) begin
      fails++;
      $display("FAIL bubble_result: valid=%b idx=%0d score=%0d, required 1/9/10", class_valid, class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    tests++;
    if (class_margin !== 32'd1) begin
      fails++;
      $display("FAIL bubble_margin: margin=%0d, required 1", class_margin);
    end
`endif
    class_ready = 1'b1;
    @(negedge clk);
    class_ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    score_t f[CLASS_COUNT] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'hFFFF_FFFF, 32'd7, 32'd8, 32'd9};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      score_valid = 1'b1;
      score_data  = 32'd1000 + i;
      @(negedge clk);
    end
    score_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (class_valid !== 1'b0 || score_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_state: class_valid=%b score_ready=%b, required 0/1", class_valid, score_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    send_frame(f, 0, cyc);
    tests++;
    if (cyc !== 10 || class_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_latency: cycles=%0d valid=%b, required 10/1", cyc, class_valid);
    end
    tests++;
    if (class_idx !== class_idx_t'(6) || class_score !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL mid_reset_result: idx=%0d score=%h, required 6/ffffffff", class_idx, class_score);
    end
`ifdef ARGMAX_MARGIN_EN
    tests++;
    if (class_margin !== 32'hFFFF_FFF6) begin
      fails++;
      $display("FAIL mid_reset_margin: margin=%h, required fffffff6", class_margin);
    end
`endif
    class_ready = 1'b1;
    @(negedge clk);
    class_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    score_t f[2*CLASS_COUNT] = '{32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd9, 32'd2, 32'd6, 32'd5, 32'd3,
                                 32'd8, 32'd8, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7};
    int         j;
    int         nres;
    int         when[2];
    class_idx_t ridx[2];
    score_t     rscore[2];
    j = 0;
    nres = 0;
    class_ready = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (class_valid === 1'b1) begin
        if (nres < 2) begin
          when[nres]   = c;
          ridx[nres]   = class_idx;
          rscore[nres] = class_score;
        end
        nres++;
      end
      if (j < 2*CLASS_COUNT) begin
        score_valid = 1'b1;
        score_data  = f[j];
        if (score_ready === 1'b1) j++;
      end else begin
        score_valid = 1'b0;
      end
    end
    score_valid = 1'b0;
    class_ready = 1'b0;
    tests++;
    if (nres !== 2) begin
      fails++;
      $display("FAIL b2b_count: %0d results, required 2", nres);
    end else begin
      tests++;
      if (when[0] !== 11 || when[1] !== 22) begin
        fails++;
        $display("FAIL b2b_timing: results at %0d/%0d, required 11/22", when[0], when[1]);
      end
      tests++;
      if (ridx[0] !== class_idx_t'(5) || rscore[0] !== 32'd9) begin
        fails++;
        $display("FAIL b2b_first: idx=%0d score=%0d, required 5/9", ridx[0], rscore[0]);
      end
      tests++;
      if (ridx[1] !== class_idx_t'(0) || rscore[1] !== 32'd8) begin
        fails++;
        $display("FAIL b2b_second: idx=%0d score=%0d, required 0/8", ridx[1], rscore[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_all_zero();
    test_stall();
    test_bubbles();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
